// File: rtl/alu_pkg.sv
// Shared constants for the execute-stage ALU: 3-bit ALU control codes and
// the execute FSM state encoding. The ALU control decoder uses the same codes.
package alu_pkg;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_RSV = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_MUL = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLL = 3'b101;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SRA = 3'b111;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } alu_state_e;

endpackage

// File: rtl/alu_exec_mul_iter.sv
// Iterative shift-add multiplier: one multiplier bit per step, low WIDTH bits
// of the unsigned product. The top owns sequencing through load/step/clear.
module mul_iter #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic             i_step,
    input  logic             i_clear,
    input  logic [WIDTH-1:0] i_mcand,
    input  logic [WIDTH-1:0] i_mplier,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_last
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH - 1);

    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] w_addend;

    // Partial product for the current multiplier bit and the running sum it yields.
    always_comb begin
        w_addend = {WIDTH{1'b0}};
        if (r_mplier[0]) begin
            w_addend = r_mcand;
        end else begin
            w_addend = {WIDTH{1'b0}};
        end
    end

    // The sum after this step; the top writes it out on the last step.
    assign o_sum  = r_acc + w_addend;
    assign o_last = (r_cnt == {CW{1'b0}});

    // Iteration state: clear beats load beats step.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_acc    <= {WIDTH{1'b0}};
            r_mcand  <= {WIDTH{1'b0}};
            r_mplier <= {WIDTH{1'b0}};
            r_cnt    <= {CW{1'b0}};
        end else if (i_clear) begin
            r_acc    <= {WIDTH{1'b0}};
            r_mcand  <= {WIDTH{1'b0}};
            r_mplier <= {WIDTH{1'b0}};
            r_cnt    <= {CW{1'b0}};
        end else if (i_load) begin
            r_acc    <= {WIDTH{1'b0}};
            r_mcand  <= i_mcand;
            r_mplier <= i_mplier;
            r_cnt    <= CNT_LOAD;
        end else if (i_step) begin
            r_acc    <= o_sum;
            r_mcand  <= {r_mcand[WIDTH-2:0], 1'b0};
            r_mplier <= {1'b0, r_mplier[WIDTH-1:1]};
            r_cnt    <= r_cnt - {{(CW-1){1'b0}}, 1'b1};
        end else begin
            r_acc    <= r_acc;
            r_mcand  <= r_mcand;
            r_mplier <= r_mplier;
            r_cnt    <= r_cnt;
        end
    end

endmodule

// File: rtl/alu_exec.sv
// Execute-stage ALU: single-cycle ops go through one issue register and then
// the output register; MUL runs on mul_iter and holds the pipe via stall_o.
module alu_exec
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [2:0]       ALUCtrl_i,
    input  logic [WIDTH-1:0] data1_i,
    input  logic [WIDTH-1:0] data2_i,
    input  logic             flush_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o,
    output logic             zero_o,
    output logic             stall_o
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    alu_state_e       r_state;
    alu_state_e       w_next;
    logic             w_load;
    logic             w_step;
    logic             w_clear;
    logic             w_issue;
    logic             w_mul_done;
    logic             w_wr;
    logic [WIDTH-1:0] w_wr_data;
    logic [WIDTH-1:0] w_alu_res;
    logic [WIDTH-1:0] w_sum;
    logic             w_last;
    logic [4:0]       w_shamt;
    logic             r_pend_vld;
    logic [WIDTH-1:0] r_pend_res;
    logic [WIDTH-1:0] r_data;
    logic             r_valid;
    logic             r_zero;

    assign w_shamt = data2_i[4:0];

    mul_iter #(.WIDTH(WIDTH)) u_mul_iter (
        .i_clk    (clk_i),
        .i_rst    (rst_i),
        .i_load   (w_load),
        .i_step   (w_step),
        .i_clear  (w_clear),
        .i_mcand  (data1_i),
        .i_mplier (data2_i),
        .o_sum    (w_sum),
        .o_last   (w_last)
    );

    // Single-cycle datapath; reserved code and MUL produce 0 here.
    always_comb begin
        w_alu_res = {WIDTH{1'b0}};
        case (ALUCtrl_i)
            ALU_AND: w_alu_res = data1_i & data2_i;
            ALU_ADD: w_alu_res = data1_i + data2_i;
            ALU_XOR: w_alu_res = data1_i ^ data2_i;
            ALU_SLL: w_alu_res = data1_i << w_shamt;
            ALU_SUB: w_alu_res = data1_i + ~data2_i + ONE;
            ALU_SRA: w_alu_res = $signed(data1_i) >>> w_shamt;
            default: w_alu_res = {WIDTH{1'b0}};
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state and multiplier control; flush always wins over start.
    always_comb begin
        w_next     = r_state;
        w_load     = 1'b0;
        w_step     = 1'b0;
        w_clear    = 1'b0;
        w_issue    = 1'b0;
        w_mul_done = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (flush_i) begin
                    w_clear = 1'b1;
                    w_next  = ST_IDLE;
                end else if (start_i) begin
                    if (ALUCtrl_i == ALU_MUL) begin
                        w_load = 1'b1;
                        w_next = ST_MUL;
                    end else begin
                        w_issue = 1'b1;
                        w_next  = ST_IDLE;
                    end
                end else begin
                    w_next = ST_IDLE;
                end
            end
            ST_MUL: begin
                if (flush_i) begin
                    w_clear = 1'b1;
                    w_next  = ST_IDLE;
                end else begin
                    w_step = 1'b1;
                    if (w_last) begin
                        w_mul_done = 1'b1;
                        w_next     = ST_IDLE;
                    end else begin
                        w_next = ST_MUL;
                    end
                end
            end
            default: begin
                w_clear = 1'b1;
                w_next  = ST_IDLE;
            end
        endcase
    end

    // Output write select: finished MUL or a pending single-cycle result not killed by flush.
    always_comb begin
        w_wr      = 1'b0;
        w_wr_data = r_pend_res;
        if (w_mul_done) begin
            w_wr      = 1'b1;
            w_wr_data = w_sum;
        end else if (r_pend_vld && !flush_i) begin
            w_wr      = 1'b1;
            w_wr_data = r_pend_res;
        end else begin
            w_wr      = 1'b0;
            w_wr_data = r_pend_res;
        end
    end

    // Issue register for single-cycle ops, then result/valid/zero output registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_pend_vld <= 1'b0;
            r_pend_res <= {WIDTH{1'b0}};
            r_data     <= {WIDTH{1'b0}};
            r_valid    <= 1'b0;
            r_zero     <= 1'b1;
        end else begin
            r_pend_vld <= w_issue;
            r_pend_res <= w_alu_res;
            r_valid    <= w_wr;
            if (w_wr) begin
                r_data <= w_wr_data;
                r_zero <= (w_wr_data == {WIDTH{1'b0}});
            end else begin
                r_data <= r_data;
                r_zero <= r_zero;
            end
        end
    end

    assign data_o  = r_data;
    assign valid_o = r_valid;
    assign zero_o  = r_zero;
    assign stall_o = (r_state == ST_MUL);

endmodule

// File: tb/tb_alu_exec.sv
// Directed bench for alu_exec: hand-computed vectors for single-cycle ops,
// back-to-back issue, MUL latency/stall, ignored start, flush and reset abort.
module tb_alu_exec;
    import alu_pkg::*;

    logic        clk;
    logic        rst;
    logic        start;
    logic [2:0]  ctrl;
    logic [31:0] d1;
    logic [31:0] d2;
    logic        flush;
    logic [31:0] data;
    logic        valid;
    logic        zero;
    logic        stall;

    int n_checks = 0;
    int n_errors = 0;

    alu_exec #(.WIDTH(32)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .start_i   (start),
        .ALUCtrl_i (ctrl),
        .data1_i   (d1),
        .data2_i   (d2),
        .flush_i   (flush),
        .data_o    (data),
        .valid_o   (valid),
        .zero_o    (zero),
        .stall_o   (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one single-cycle op and check it lands one edge after acceptance.
    task automatic single(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
        start = 1'b1; ctrl = op; d1 = a; d2 = b;
        tick();
        start = 1'b0;
        check({tag, "_v_early"}, 32'(valid), 32'd0);
        tick();
        check({tag, "_data"}, data, exp);
        check({tag, "_valid"}, 32'(valid), 32'd1);
        check({tag, "_zero"}, 32'(zero), 32'(exp == 32'd0));
    endtask

    // Run a MUL, optionally issuing an ADD mid-way, and check stall length and result.
    task automatic mul_run(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp, input int inj_at);
        int cnt;
        int vcnt;
        cnt = 0; vcnt = 0;
        start = 1'b1; ctrl = ALU_MUL; d1 = a; d2 = b;
        tick();
        start = 1'b0;
        while (stall && cnt < 100) begin
            cnt++;
            if (valid) vcnt++;
            if (cnt == inj_at) begin
                start = 1'b1; ctrl = ALU_ADD; d1 = 32'd1; d2 = 32'd2;
            end else begin
                start = 1'b0;
            end
            tick();
        end
        start = 1'b0;
        check({tag, "_stall_cycles"}, 32'(cnt), 32'd32);
        check({tag, "_valid_in_stall"}, 32'(vcnt), 32'd0);
        check({tag, "_data"}, data, exp);
        check({tag, "_valid"}, 32'(valid), 32'd1);
        tick();
        check({tag, "_valid_after"}, 32'(valid), 32'd0);
        check({tag, "_data_hold"}, data, exp);
        check({tag, "_stall_after"}, 32'(stall), 32'd0);
    endtask

    // Abort a MUL in its 15th stalled cycle with flush or reset.
    task automatic mul_abort(input string tag, input logic use_rst, input logic [31:0] exp_data);
        start = 1'b1; ctrl = ALU_MUL; d1 = 32'd7; d2 = 32'd9;
        tick();
        start = 1'b0;
        repeat (14) tick();
        check({tag, "_stall_mid"}, 32'(stall), 32'd1);
        if (use_rst) rst = 1'b1;
        else flush = 1'b1;
        tick();
        rst = 1'b0; flush = 1'b0;
        check({tag, "_stall"}, 32'(stall), 32'd0);
        check({tag, "_valid"}, 32'(valid), 32'd0);
        check({tag, "_data"}, data, exp_data);
        check({tag, "_zero"}, 32'(zero), 32'(exp_data == 32'd0));
        repeat (20) begin
            tick();
            if (valid || stall) check({tag, "_late_activity"}, {30'd0, valid, stall}, 32'd0);
        end
    endtask

    logic [2:0]  b_op  [4] = '{ALU_ADD, ALU_XOR, ALU_SUB, ALU_SLL};
    logic [31:0] b_a   [4] = '{32'h1234_5678, 32'hFF00_FF00, 32'd10, 32'h0000_0003};
    logic [31:0] b_b   [4] = '{32'h1111_1111, 32'h0F0F_0F0F, 32'd10, 32'h0000_0024};
    logic [31:0] b_exp [4] = '{32'h2345_6789, 32'hF00F_F00F, 32'd0,  32'h0000_0030};

    initial begin
        rst = 1'b1; start = 1'b0; ctrl = ALU_AND; d1 = 32'd0; d2 = 32'd0; flush = 1'b0;
        tick(); tick();
        rst = 1'b0;
        repeat (3) tick();
        check("rst_data", data, 32'd0);
        check("rst_zero", 32'(zero), 32'd1);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_stall", 32'(stall), 32'd0);

        single("sub", ALU_SUB, 32'd5, 32'd7, 32'hFFFF_FFFE);
        single("sra", ALU_SRA, 32'h8000_0000, 32'd4, 32'hF800_0000);
        single("sll", ALU_SLL, 32'd1, 32'd31, 32'h8000_0000);
        single("and", ALU_AND, 32'h0000_F0F0, 32'h0000_0FF0, 32'h0000_00F0);
        single("rsv", ALU_RSV, 32'h0000_FFFF, 32'd1, 32'd0);

        for (int i = 0; i < 5; i++) begin
            if (i < 4) begin
                start = 1'b1; ctrl = b_op[i]; d1 = b_a[i]; d2 = b_b[i];
            end else begin
                start = 1'b0;
            end
            tick();
            if (i > 0) begin
                check("b2b_data", data, b_exp[i-1]);
                check("b2b_valid", 32'(valid), 32'd1);
                check("b2b_zero", 32'(zero), 32'(b_exp[i-1] == 32'd0));
            end
        end
        tick();
        check("b2b_valid_end", 32'(valid), 32'd0);

        mul_run("mul_ff_x3", 32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFFD, -1);
        mul_run("mul_dec_inj", 32'd12345, 32'd6789, 32'd83810205, 10);

        mul_abort("flush_mid", 1'b0, 32'd83810205);
        mul_abort("rst_mid", 1'b1, 32'd0);

        start = 1'b1; flush = 1'b1; ctrl = ALU_MUL; d1 = 32'd3; d2 = 32'd5;
        tick();
        start = 1'b0; flush = 1'b0;
        check("fs_stall", 32'(stall), 32'd0);
        check("fs_valid", 32'(valid), 32'd0);
        tick();
        check("fs_valid2", 32'(valid), 32'd0);
        check("fs_stall2", 32'(stall), 32'd0);
        check("fs_data", data, 32'd0);

        mul_run("mul_after", 32'd5, 32'd7, 32'd35, -1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
